// File: rtl/usrt_cfg_regs.sv
// APB-style configuration/status registers and baud tick generator for the USRT.
// Define USRT_DIV_OVERRIDE_EN to add the DIVLO/DIVHI custom-divisor registers at addr2/3.
module usrt_cfg_regs #(
  parameter int P_CLK_HZ = 10_000_000,
  parameter int P_DIV_W  = 14,
  parameter int P_ADDR_W = 2
) (
  input  logic                i_Pclk,
  input  logic                i_Preset,
  input  logic                i_Psel,
  input  logic                i_Penable,
  input  logic                i_Pwrite,
  input  logic [P_ADDR_W-1:0] i_Paddr,
  input  logic [7:0]          i_Pwdata,
  output logic [7:0]          o_Prdata,
  output logic                o_Pready,
  input  logic                i_TxBusy,
  input  logic                i_RxValid,
  input  logic                i_ParityErr,
  input  logic                i_FrameErr,
  input  logic                i_Overrun,
  output logic [P_DIV_W-1:0]  o_Divisor,
  output logic [1:0]          o_Parity,
  output logic                o_TwoStop,
  output logic                o_TxEn,
  output logic                o_RxEn,
  output logic                o_BaudTick,
  output logic                o_Irq
);

  localparam logic [P_DIV_W-1:0] DIV_1200   = P_DIV_W'(P_CLK_HZ / 1200);
  localparam logic [P_DIV_W-1:0] DIV_2400   = P_DIV_W'(P_CLK_HZ / 2400);
  localparam logic [P_DIV_W-1:0] DIV_4800   = P_DIV_W'(P_CLK_HZ / 4800);
  localparam logic [P_DIV_W-1:0] DIV_9600   = P_DIV_W'(P_CLK_HZ / 9600);
  localparam logic [P_DIV_W-1:0] DIV_19200  = P_DIV_W'(P_CLK_HZ / 19200);
  localparam logic [P_DIV_W-1:0] DIV_38400  = P_DIV_W'(P_CLK_HZ / 38400);
  localparam logic [P_DIV_W-1:0] DIV_57600  = P_DIV_W'(P_CLK_HZ / 57600);
  localparam logic [P_DIV_W-1:0] DIV_115200 = P_DIV_W'(P_CLK_HZ / 115200);
  localparam logic [P_DIV_W-1:0] ONE        = P_DIV_W'(1);
  localparam logic [7:0]         CTRL_RST   = 8'h03;

  function automatic logic [P_DIV_W-1:0] table_div(input logic [2:0] sel);
    logic [P_DIV_W-1:0] d;
    case (sel)
      3'd0:    d = DIV_1200;
      3'd1:    d = DIV_2400;
      3'd2:    d = DIV_4800;
      3'd3:    d = DIV_9600;
      3'd4:    d = DIV_19200;
      3'd5:    d = DIV_38400;
      3'd6:    d = DIV_57600;
      default: d = DIV_115200;
    endcase
    return d;
  endfunction

  logic [7:0]         ctrl_q, ctrl_d;
  logic [2:0]         sticky_q, sticky_d;
  logic               irq_q;
  logic               pready_q, pready_d;
  logic [7:0]         prdata_q, prdata_d;
  logic [P_DIV_W-1:0] cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic [P_DIV_W-1:0] div_cur, div_nxt;
  logic               access, wr_en;
  logic [7:0]         rdata;
  logic [2:0]         w1c;

  assign access = i_Psel & i_Penable & ~pready_q;
  assign wr_en  = access & i_Pwrite;

`ifdef USRT_DIV_OVERRIDE_EN
  localparam int         HI_W    = P_DIV_W - 8;
  localparam logic [7:0] HI_MASK = 8'h80 | 8'((1 << HI_W) - 1);

  logic [7:0] divlo_q, divlo_d;
  logic [7:0] divhi_q, divhi_d;

  // A custom divisor of 0 would stall the counter, so it behaves as 1.
  function automatic logic [P_DIV_W-1:0] div_sel(input logic [7:0] ctrl,
                                                 input logic [7:0] lo,
                                                 input logic [7:0] hi);
    logic [P_DIV_W-1:0] custom;
    logic [P_DIV_W-1:0] d;
    custom = {hi[HI_W-1:0], lo};
    if (!hi[7])             d = table_div(ctrl[2:0]);
    else if (custom == '0)  d = ONE;
    else                    d = custom;
    return d;
  endfunction

  always_comb begin
    divlo_d = divlo_q;
    divhi_d = divhi_q;
    if (wr_en && i_Paddr == P_ADDR_W'(2)) divlo_d = i_Pwdata;
    if (wr_en && i_Paddr == P_ADDR_W'(3)) divhi_d = i_Pwdata & HI_MASK;
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      divlo_q <= '0;
      divhi_q <= '0;
    end else begin
      divlo_q <= divlo_d;
      divhi_q <= divhi_d;
    end
  end

  assign div_cur = div_sel(ctrl_q, divlo_q, divhi_q);
  assign div_nxt = div_sel(ctrl_d, divlo_d, divhi_d);
`else
  assign div_cur = table_div(ctrl_q[2:0]);
  assign div_nxt = table_div(ctrl_d[2:0]);
`endif

  always_comb begin
    rdata = '0;
    if (i_Paddr == P_ADDR_W'(0))      rdata = ctrl_q;
    else if (i_Paddr == P_ADDR_W'(1)) rdata = {3'b000, sticky_q, i_RxValid, i_TxBusy};
`ifdef USRT_DIV_OVERRIDE_EN
    else if (i_Paddr == P_ADDR_W'(2)) rdata = divlo_q;
    else if (i_Paddr == P_ADDR_W'(3)) rdata = divhi_q;
`endif
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en && i_Paddr == P_ADDR_W'(0)) ctrl_d = i_Pwdata;

    w1c = '0;
    if (wr_en && i_Paddr == P_ADDR_W'(1)) w1c = i_Pwdata[4:2];
    // Event OR-ed in after the clear so a coincident event survives.
    sticky_d = (sticky_q & ~w1c) | {i_Overrun, i_FrameErr, i_ParityErr};

    pready_d = access;
    prdata_d = access ? rdata : prdata_q;

    tick_d = 1'b0;
    if (div_nxt != div_cur)            cnt_d = div_nxt - ONE;
    else if (!(ctrl_q[6] | ctrl_q[7])) cnt_d = div_cur - ONE;
    else if (cnt_q == '0) begin
      tick_d = 1'b1;
      cnt_d  = div_cur - ONE;
    end else                           cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      ctrl_q   <= CTRL_RST;
      sticky_q <= '0;
      irq_q    <= 1'b0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      cnt_q    <= DIV_9600 - ONE;
      tick_q   <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      sticky_q <= sticky_d;
      irq_q    <= |sticky_q;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign o_Prdata   = prdata_q;
  assign o_Pready   = pready_q;
  assign o_Divisor  = div_cur;
  assign o_Parity   = (ctrl_q[4:3] == 2'b11) ? 2'b00 : ctrl_q[4:3];
  assign o_TwoStop  = ctrl_q[5];
  assign o_TxEn     = ctrl_q[6];
  assign o_RxEn     = ctrl_q[7];
  assign o_BaudTick = tick_q;
  assign o_Irq      = irq_q;

endmodule

// File: tb/tb_usrt_cfg_regs.sv
// Directed plus randomized check of usrt_cfg_regs against a register-level reference model.
module tb_usrt_cfg_regs;
  localparam int CLK_HZ = 10_000_000;
  localparam int DIV_W  = 14;
  localparam int AW     = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [7:0]       pwdata;
  logic [7:0]       prdata;
  logic             pready;
  logic             txb, rxv, par, frm, ovr;
  logic [DIV_W-1:0] divisor;
  logic [1:0]       parity;
  logic             two_stop, tx_en, rx_en, tick, irq;

  usrt_cfg_regs #(.P_CLK_HZ(CLK_HZ), .P_DIV_W(DIV_W), .P_ADDR_W(AW)) dut (
    .i_Pclk(clk), .i_Preset(rst), .i_Psel(psel), .i_Penable(penable), .i_Pwrite(pwrite),
    .i_Paddr(paddr), .i_Pwdata(pwdata), .o_Prdata(prdata), .o_Pready(pready),
    .i_TxBusy(txb), .i_RxValid(rxv), .i_ParityErr(par), .i_FrameErr(frm), .i_Overrun(ovr),
    .o_Divisor(divisor), .o_Parity(parity), .o_TwoStop(two_stop), .o_TxEn(tx_en),
    .o_RxEn(rx_en), .o_BaudTick(tick), .o_Irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tick_cnt = 0, last_tick = 0, prev_tick = 0;
  int commit_cyc = 0;
  logic tick_at_commit;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tick === 1'b1) begin
    prev_tick = last_tick;
    last_tick = cyc;
    tick_cnt++;
  end

  // reference model state
  int         rates [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};
  logic [7:0] m_ctrl, m_divlo, m_divhi;
  logic [2:0] m_sticky;

  function automatic int exp_div();
    int d;
    d = CLK_HZ / rates[m_ctrl[2:0]];
`ifdef USRT_DIV_OVERRIDE_EN
    if (m_divhi[7]) begin
      d = m_divhi[5:0] * 256 + m_divlo;
      if (d == 0) d = 1;
    end
`endif
    return d;
  endfunction

  function automatic logic [1:0] exp_parity();
    return (m_ctrl[4:3] == 2'd3) ? 2'd0 : m_ctrl[4:3];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [1:0] a, input logic [7:0] d,
                          input logic [2:0] ev, output logic [7:0] rdat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    chk("pready_setup", pready, 0);
    penable = 1'b1;
    {ovr, frm, par} = ev;
    @(posedge clk); #1;
    commit_cyc = cyc;
    tick_at_commit = tick;
    chk("pready_commit", pready, 1);
    rdat = prdata;
    {ovr, frm, par} = 3'b000;
    @(posedge clk); #1;
    chk("pready_drop", pready, 0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] x;
    apb_xfer(1'b1, a, d, 3'b000, x);
  endtask

  task automatic wr_ev(input logic [1:0] a, input logic [7:0] d, input logic [2:0] ev);
    logic [7:0] x;
    apb_xfer(1'b1, a, d, ev, x);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] x;
    apb_xfer(1'b0, a, 8'h00, 3'b000, x);
    chk(tag, x, exp);
  endtask

  task automatic pulse_ev(input logic [2:0] ev);
    @(posedge clk); #1;
    {ovr, frm, par} = ev;
    @(posedge clk); #1;
    {ovr, frm, par} = 3'b000;
  endtask

  task automatic wait_ticks(input int n, input int budget, input string tag);
    int start;
    int i;
    start = tick_cnt;
    i = 0;
    while (tick_cnt < start + n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk({tag, "_wait"}, tick_cnt - start, n);
  endtask

  task automatic chk_cfg(input string tag);
    chk({tag, "_div"}, divisor, exp_div());
    chk({tag, "_par"}, parity, exp_parity());
    chk({tag, "_stop"}, two_stop, m_ctrl[5]);
    chk({tag, "_txen"}, tx_en, m_ctrl[6]);
    chk({tag, "_rxen"}, rx_en, m_ctrl[7]);
  endtask

  initial begin
    int t0, c, n;
    logic [7:0] v, w;
    logic [2:0] ev;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    txb = 1'b0; rxv = 1'b0; par = 1'b0; frm = 1'b0; ovr = 1'b0;
    m_ctrl = 8'h03; m_sticky = '0; m_divlo = '0; m_divhi = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_pready", pready, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_tick", tick, 0);
    chk("rst_irq", irq, 0);
    chk_cfg("rst");
    rst = 1'b0;

    rd(2'd0, 8'h03, "ctrl_rst");
    rd(2'd1, 8'h00, "status_rst");
    t0 = tick_cnt;
    repeat (5000) @(posedge clk);
    #1 chk("idle_no_tick", tick_cnt - t0, 0);

    // enable at 115200
    wr(2'd0, 8'hC7); m_ctrl = 8'hC7;
    chk_cfg("c7");
    chk("c7_commit_tick", tick_at_commit, 0);
    c = commit_cyc;
    wait_ticks(1, 200, "c7_first");
    chk("c7_first_gap", last_tick - c, 86);
    wait_ticks(1, 200, "c7_second");
    chk("c7_period", last_tick - prev_tick, 86);

    // same divisor, parity field 11: count must not be disturbed
    t0 = last_tick;
    wr(2'd0, 8'hDF); m_ctrl = 8'hDF;
    wait_ticks(1, 200, "df_tick");
    chk("df_undisturbed", last_tick - t0, 86);
    chk_cfg("df");
    rd(2'd0, 8'hDF, "df_readback");

    // sticky frame error, irq one edge behind the flag
    pulse_ev(3'b010); m_sticky = m_sticky | 3'b010;
    chk("irq_lag", irq, 0);
    @(posedge clk); #1;
    chk("irq_set", irq, 1);
    rd(2'd1, {3'b000, m_sticky, 2'b00}, "status_frm");
    wr_ev(2'd1, 8'h08, 3'b010);
    rd(2'd1, {3'b000, m_sticky, 2'b00}, "status_set_wins");
    chk("irq_still", irq, 1);
    wr(2'd1, 8'h08); m_sticky = m_sticky & ~3'b010;
    rd(2'd1, {3'b000, m_sticky, 2'b00}, "status_cleared");
    chk("irq_clear", irq, 0);

    // mid-count rate change
    wait_ticks(1, 200, "mid_sync");
    repeat ($urandom_range(60, 10)) @(posedge clk);
    wr(2'd0, 8'hC4); m_ctrl = 8'hC4;
    chk("mid_commit_tick", tick_at_commit, 0);
    c = commit_cyc;
    chk_cfg("c4");
    wait_ticks(1, 700, "c4_first");
    chk("c4_first_gap", last_tick - c, 520);
    wait_ticks(1, 700, "c4_second");
    chk("c4_period", last_tick - prev_tick, 520);

`ifdef USRT_DIV_OVERRIDE_EN
    wr(2'd2, 8'h0A); m_divlo = 8'h0A;
    chk("divlo_only", divisor, exp_div());
    wr(2'd3, 8'h80); m_divhi = 8'h80;
    chk("ovr_div", divisor, 10);
    c = commit_cyc;
    wait_ticks(1, 50, "ovr_first");
    chk("ovr_first_gap", last_tick - c, 10);
    wait_ticks(1, 50, "ovr_second");
    chk("ovr_period", last_tick - prev_tick, 10);
    rd(2'd2, 8'h0A, "divlo_rb");
    rd(2'd3, 8'h80, "divhi_rb");
    wr(2'd2, 8'h00); m_divlo = 8'h00;
    chk("ovr_zero_div", divisor, 1);
    wait_ticks(2, 20, "ovr_zero");
    chk("ovr_zero_period", last_tick - prev_tick, 1);
    wr(2'd3, 8'h00); m_divhi = 8'h00;
    chk("ovr_off_div", divisor, exp_div());
`else
    wr(2'd2, 8'hFF);
    wr(2'd3, 8'hFF);
    rd(2'd2, 8'h00, "addr2_unmapped");
    rd(2'd3, 8'h00, "addr3_unmapped");
    chk("unmapped_div", divisor, exp_div());
`endif

    // both enables off: counter frozen
    wr(2'd0, 8'h04); m_ctrl = 8'h04;
    chk_cfg("off");
    t0 = tick_cnt;
    repeat (1500) @(posedge clk);
    #1 chk("off_no_tick", tick_cnt - t0, 0);

    for (int k = 0; k < 24; k++) begin
      v = 8'($urandom);
      wr(2'd0, v); m_ctrl = v;
      chk_cfg("rnd");
      rd(2'd0, v, "rnd_ctrl_rb");
      txb = 1'($urandom); rxv = 1'($urandom);
      ev = 3'($urandom);
      pulse_ev(ev); m_sticky = m_sticky | ev;
      w = 8'($urandom);
      wr(2'd1, w); m_sticky = m_sticky & ~w[4:2];
      rd(2'd1, {3'b000, m_sticky, rxv, txb}, "rnd_status");
      chk("rnd_irq", irq, |m_sticky);
    end

    n = $urandom_range(7, 3);
    v = {2'b11, 3'b000, 3'(n)};
    wr(2'd0, v); m_ctrl = v;
    wait_ticks(2, 2200, "rnd_rate");
    chk("rnd_period", last_tick - prev_tick, exp_div());

    // reset in the middle of an access
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = 2'd0; pwdata = 8'hAA;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pready", pready, 0);
    chk("mid_rst_prdata", prdata, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_div", divisor, 1041);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; txb = 1'b0; rxv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ctrl = 8'h03; m_sticky = '0; m_divlo = '0; m_divhi = '0;
    rd(2'd0, 8'h03, "post_rst_ctrl");
    rd(2'd1, 8'h00, "post_rst_status");
    chk_cfg("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usrt_cfg_regs.md
Name: usrt_cfg_regs

Overview:
Parametrised successor to the USRT status register. It is an APB-style slave exposing a control register, a sticky W1C status register and an optional custom-divisor register pair. It derives parity mode, stop bits, enables and the baud divisor, and generates a free-running baud tick for the TX/RX engines. It sits between the APB bus and the USRT datapath.

Parameters:
P_CLK_HZ, 10000000, pclk frequency; table divisor = P_CLK_HZ / rate, integer truncation.
P_DIV_W, 14, width of divisor and baud counter; every table divisor must fit.
P_ADDR_W, 2, APB address width; addresses 0..3 decoded.

Ports:
i_Pclk  in  1  clock, all logic rising-edge.
i_Preset  in  1  asynchronous, active-high reset.
i_Psel  in  1  APB select.
i_Penable  in  1  APB access phase.
i_Pwrite  in  1  1 = write, 0 = read.
i_Paddr  in  P_ADDR_W  register address.
i_Pwdata  in  8  write data.
o_Prdata  out  8  read data; valid while o_Pready=1.
o_Pready  out  1  transfer-complete pulse.
i_TxBusy  in  1  live TX-busy level.
i_RxValid  in  1  live RX-data-valid level.
i_ParityErr  in  1  1-cycle parity-error event.
i_FrameErr  in  1  1-cycle framing-error event.
i_Overrun  in  1  1-cycle overrun event.
o_Divisor  out  P_DIV_W  active baud divisor.
o_Parity  out  2  00 none, 01 even, 10 odd.
o_TwoStop  out  1  1 = two stop bits.
o_TxEn  out  1  transmitter enable.
o_RxEn  out  1  receiver enable.
o_BaudTick  out  1  1-cycle pulse every o_Divisor cycles.
o_Irq  out  1  OR of the sticky status flags.

Behaviour:
- Register map:
  - addr0 CTRL (RW): [2:0] baud sel, [4:3] parity, [5] two-stop, [6] TxEn, [7] RxEn.
  - addr1 STATUS: [0] TxBusy (RO, live), [1] RxValid (RO, live), [2] parity err, [3] frame err, [4] overrun (sticky, W1C), [7:5] read 0.
  - addr2/3: see optional feature.
- Reset values: CTRL = 8'h03; sticky flags = 0; o_Pready = 0; o_Prdata = 0; o_BaudTick = 0; baud counter = divisor-1; o_Divisor = 1041 at default P_CLK_HZ.
- Baud table (rates): sel 0..7 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200 bps. Default values: 8333, 4166, 2083, 1041, 520, 260, 173, 86.
- Parity field 11 decodes as 00 (none). CTRL readback returns the raw stored value.
- APB handshake:
  - At the first edge where Psel&Penable=1 and o_Pready=0: write is committed, o_Prdata is loaded and o_Pready is set to 1.
  - At the next edge o_Pready returns to 0. This gives exactly one wait state.
  - No second commit occurs while o_Pready=1.
  - Psel without Penable has no effect.
- Read of an unmapped address returns 0. Write to an unmapped address is ignored.
- Sticky flags:
  - Each is set by its event input in any cycle.
  - Each is cleared by writing 1 to its STATUS bit.
  - If an event and a W1C clear hit the same bit in the same cycle, set wins.
  - Writes to RO bits are ignored.
- o_Irq is registered: it equals the OR of the sticky flags as of the previous edge.
- Baud counter:
  - Down-counter, active only when TxEn|RxEn.
  - On reaching 0: o_BaudTick=1 for one cycle and the counter reloads divisor-1, so the tick period is exactly o_Divisor cycles.
  - When both enables are 0: counter held at divisor-1, no ticks.
  - Any write that changes o_Divisor reloads the counter to new divisor-1 at the commit edge, with no tick that cycle. A write that leaves the divisor unchanged does not disturb the count.
- Reset asserted mid-transfer: all state returns to reset values immediately. The master must restart the transfer.

Optional Feature:
- Macro USRT_DIV_OVERRIDE_EN.
- Defined:
  - addr2 DIVLO (RW) holds divisor[7:0].
  - addr3 DIVHI (RW) holds [P_DIV_W-9:0] = divisor upper bits and [7] = override enable.
  - When override=1, o_Divisor is the custom value, with 0 treated as 1; otherwise the table value is used.
  - Reset: DIVLO = 0, DIVHI = 0.
- Undefined: addr2/3 read 0, writes are ignored, and the table divisor is always used.

Test Plan:
- Reset, then read CTRL and STATUS -> 8'h03 and 8'h00; o_Divisor = 1041; o_BaudTick stays 0 for 5000 cycles.
- Write CTRL = 8'hC7 -> o_Pready high exactly 1 cycle after access start; o_Divisor = 86; ticks every 86 cycles; o_Parity = 00; TxEn = RxEn = 1.
- Write CTRL = 8'hDF (sel 7, parity field 11) -> o_Parity = 00; CTRL readback = 8'hDF.
- Pulse i_FrameErr -> STATUS[3] = 1 and o_Irq = 1 one edge later. Write STATUS = 8'h08 in the same cycle as another i_FrameErr pulse -> bit stays 1. A second clear -> bit 0, o_Irq 0.
- While ticking at 86, change sel 7 -> 4 mid-count -> no tick at the commit edge; first tick exactly 520 cycles later.
- USRT_DIV_OVERRIDE_EN defined: write DIVLO = 8'h0A, DIVHI = 8'h80 -> o_Divisor = 10, ticks every 10 cycles. Then DIVHI = 8'h00 -> table divisor restored.
